button_press_classifier: RTL and testbench

- Converts one raw mechanical pushbutton into the sticky `short_press` / `long_press` flags that the wrapper's memory-mapped button registers sample and return to the CPU.
- One instance per physical button, clocked from the 50 MHz PLL output.
- Contains a 2-FF synchronizer, an integrating debouncer and a hold-time FSM.
- Each flag stays set until the CPU-side read logic pulses the matching clear, so polling software never misses an event.

---
 rtl/button_press_classifier.sv | 103 ++++++++++
 tb/tb_button_press_classifier.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_press_classifier.sv
// Pushbutton front end: 2-FF synchronizer, integrating debouncer and a hold-time
// FSM that raises sticky short/long press flags until the CPU clears them.
module button_press_classifier #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 25000000,
   parameter int CNT_W           = 25
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_raw,
   input  logic clear_short,
   input  logic clear_long,
   output logic pressed,
   output logic short_press,
   output logic long_press
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HOLD      = 2'd1,
      LONG_HELD = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic             stable;
   logic [CNT_W-1:0] db_cnt;
   logic [CNT_W-1:0] hold_cnt;
   state_t           state;
   logic             short_set;
   logic             long_set;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // A release on the very last hold cycle is neither short nor long.
   always_comb begin
      short_set = 1'b0;
      long_set  = 1'b0;
      if (state == HOLD) begin
         short_set = !stable && (hold_cnt < HOLD_LAST);
         long_set  = stable && (hold_cnt == HOLD_LAST);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         stable      <= 1'b0;
         db_cnt      <= '0;
         hold_cnt    <= '0;
         state       <= IDLE;
         pressed     <= 1'b0;
         short_press <= 1'b0;
         long_press  <= 1'b0;
      end else begin
         s1      <= btn_raw;
         s2      <= s1;
         pressed <= stable;

         if (s2 == stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            stable <= ~stable;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + CNT_W'(1);
         end

         case (state)
            IDLE: begin
               if (stable) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
               end
            end
            HOLD: begin
               if (!stable)
                  state <= IDLE;
               else if (long_set)
                  state <= LONG_HELD;
               else
                  hold_cnt <= sat_inc(hold_cnt);
            end
            LONG_HELD: begin
               if (!stable)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Set has priority over a simultaneous clear.
         short_press <= short_set | (short_press & ~clear_short);
         long_press  <= long_set | (long_press & ~clear_long);
      end
   end

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier: table of press lengths, hand-written corner
// sequences, and a random phase checked against a sample-history reference model.
module tb_button_press_classifier;

   localparam int DEB  = 4;
   localparam int LONG = 20;
   localparam int CW   = 6;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic btn_raw = 1'b0;
   logic clear_short = 1'b0;
   logic clear_long = 1'b0;
   logic pressed;
   logic short_press;
   logic long_press;

   int n_cmp = 0;
   int n_bad = 0;

   button_press_classifier #(
      .DEBOUNCE_CYCLES(DEB),
      .LONG_CYCLES    (LONG),
      .CNT_W          (CW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .btn_raw    (btn_raw),
      .clear_short(clear_short),
      .clear_long (clear_long),
      .pressed    (pressed),
      .short_press(short_press),
      .long_press (long_press)
   );

   always #5 clock = ~clock;

   // Reference model: raw input delayed two samples, stable level accepted once
   // the last DEB delayed samples all disagree with it, and a press is classified
   // by how many clock edges the stable level stayed high.
   logic m_s1 = 1'b0;
   logic m_s2 = 1'b0;
   logic m_stable = 1'b0;
   logic m_pressed = 1'b0;
   logic m_short = 1'b0;
   logic m_long = 1'b0;
   int   m_run = 0;
   logic hist[$];

   task automatic chk(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: {pressed,short,long} got %b, expected %b", name, $time, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic tick();
      logic old_stable;
      logic s_set;
      logic l_set;
      logic all_diff;
      @(posedge clock);
      if (!reset) begin
         m_s1 = 1'b0; m_s2 = 1'b0; m_stable = 1'b0; m_pressed = 1'b0;
         m_short = 1'b0; m_long = 1'b0; m_run = 0;
         hist.delete();
      end else begin
         old_stable = m_stable;
         s_set = 1'b0;
         l_set = 1'b0;
         if (old_stable) begin
            m_run++;
            if (m_run == LONG + 1) l_set = 1'b1;
         end else begin
            if (m_run > 0 && m_run < LONG) s_set = 1'b1;
            m_run = 0;
         end
         hist.push_back(m_s2);
         if (hist.size() > DEB) void'(hist.pop_front());
         all_diff = (hist.size() == DEB);
         foreach (hist[i]) if (hist[i] == old_stable) all_diff = 1'b0;
         if (all_diff) m_stable = ~old_stable;
         m_pressed = old_stable;
         m_s2 = m_s1;
         m_s1 = btn_raw;
         m_short = s_set | (m_short & ~clear_short);
         m_long  = l_set | (m_long & ~clear_long);
      end
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear_both();
      clear_short = 1'b1;
      clear_long  = 1'b1;
      tick();
      clear_short = 1'b0;
      clear_long  = 1'b0;
   endtask

   typedef struct {
      int   hold;
      logic exp_short;
      logic exp_long;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int   k;
      int   run_left;
      logic seen;

      vecs[0] = '{3,  1'b0, 1'b0};
      vecs[1] = '{4,  1'b1, 1'b0};
      vecs[2] = '{12, 1'b1, 1'b0};
      vecs[3] = '{19, 1'b1, 1'b0};
      vecs[4] = '{20, 1'b0, 1'b0};
      vecs[5] = '{21, 1'b0, 1'b1};
      vecs[6] = '{40, 1'b0, 1'b1};

      // Reset with the button held, then measure latency to pressed.
      reset = 1'b0;
      btn_raw = 1'b1;
      run(3);
      chk("reset_pressed", pressed, 1'b0);
      chk("reset_short", short_press, 1'b0);
      chk("reset_long", long_press, 1'b0);
      reset = 1'b1;
      k = 0;
      while (pressed !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      chk_range("reset_latency", k, 6, 8);
      btn_raw = 1'b0;
      run(40);
      clear_both();

      // Glitch rejection.
      seen = 1'b0;
      btn_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin tick(); seen |= pressed; end
      btn_raw = 1'b0;
      for (int i = 0; i < 10; i++) begin tick(); seen |= pressed; end
      chk("glitch_pressed", seen, 1'b0);
      chk("glitch_short", short_press, 1'b0);
      chk("glitch_long", long_press, 1'b0);

      // Press-length table.
      foreach (vecs[v]) begin
         btn_raw = 1'b1;
         run(vecs[v].hold);
         btn_raw = 1'b0;
         run(40);
         chk($sformatf("table_h%0d_short", vecs[v].hold), short_press, vecs[v].exp_short);
         chk($sformatf("table_h%0d_long", vecs[v].hold), long_press, vecs[v].exp_long);
         chk($sformatf("table_h%0d_pressed", vecs[v].hold), pressed, 1'b0);
         clear_both();
      end

      // Short press persists, then clears the cycle after the strobe.
      btn_raw = 1'b1;
      run(12);
      btn_raw = 1'b0;
      run(50);
      chk("short_sticky", short_press, 1'b1);
      chk("short_no_long", long_press, 1'b0);
      clear_short = 1'b1;
      tick();
      clear_short = 1'b0;
      chk("short_cleared", short_press, 1'b0);

      // Long press rises while still held.
      btn_raw = 1'b1;
      k = 0;
      seen = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (long_press === 1'b1 && k == 0) begin
            k = i;
            seen = pressed;
         end
      end
      chk_range("long_latency", k, 26, 28);
      chk("long_while_pressed", seen, 1'b1);
      btn_raw = 1'b0;
      run(30);
      chk("long_no_short", short_press, 1'b0);
      chk("long_sticky", long_press, 1'b1);
      clear_both();

      // Clear colliding with the set edge: set wins.
      btn_raw = 1'b1;
      run(26);
      chk("collide_before", long_press, 1'b0);
      clear_long = 1'b1;
      tick();
      clear_long = 1'b0;
      chk("collide_set_wins", long_press, 1'b1);
      run(14);
      btn_raw = 1'b0;
      run(30);
      clear_long = 1'b1;
      tick();
      clear_long = 1'b0;
      chk("collide_clear", long_press, 1'b0);
      chk("collide_no_short", short_press, 1'b0);

      // Reset in the middle of a hold discards the elapsed hold time.
      btn_raw = 1'b1;
      run(15);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("midreset_pressed", pressed, 1'b0);
      chk("midreset_long", long_press, 1'b0);
      k = 0;
      seen = 1'b0;
      while (long_press !== 1'b1 && k < 60) begin
         tick();
         k++;
         seen |= short_press;
      end
      chk_range("midreset_long_latency", k, 27, 27);
      chk("midreset_no_short", seen, 1'b0);
      btn_raw = 1'b0;
      run(30);
      clear_both();

      // Random stimulus against the reference model.
      run_left = 0;
      for (int c = 0; c < 4000; c++) begin
         if (run_left == 0) begin
            btn_raw = ~btn_raw;
            run_left = $urandom_range(1, 40);
         end
         run_left--;
         clear_short = ($urandom_range(0, 15) == 0);
         clear_long  = ($urandom_range(0, 15) == 0);
         reset       = ($urandom_range(0, 599) != 0);
         tick();
         chk3("random", {pressed, short_press, long_press}, {m_pressed, m_short, m_long});
      end
      reset = 1'b1;
      clear_short = 1'b0;
      clear_long = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
